// File: rtl/lbp_host_mem.sv
// rtl/lbp_host_mem.sv - LBP engine image memory responder and gray/lbp result collector
// Optional protocol checker enabled by defining LBP_HOST_PROTOCOL_CHECK_EN.
module lbp_host_mem #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384,
    parameter int PIX_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [PIX_W-1:0]  load_data,
    input  logic              load_done,
    output logic              RGB_ready,
    input  logic              RGB_req,
    input  logic [ADDR_W-1:0] RGB_addr,
    output logic [PIX_W-1:0]  RGB_data,
    input  logic              gray_valid,
    input  logic [ADDR_W-1:0] gray_addr,
    input  logic [7:0]        gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    input  logic              rd_sel,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [ADDR_W:0]   gray_cnt,
    output logic [ADDR_W:0]   lbp_cnt,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] CNT_MAX = CNT_W'(DEPTH);

    typedef enum logic [1:0] {EMPTY, LOADING, SERVE, COMPLETE} state_t;

    state_t state, state_next;

    logic [PIX_W-1:0] image_mem [DEPTH];
    logic [7:0]       gray_mem  [DEPTH];
    logic [7:0]       lbp_mem   [DEPTH];

    logic load_en, gray_en, lbp_en;

    assign load_en = load_valid && (state == EMPTY || state == LOADING);
    assign gray_en = gray_valid && (state == SERVE || state == COMPLETE);
    assign lbp_en  = lbp_valid  && (state == SERVE || state == COMPLETE);

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                // load_done with no load reuses whatever image is already held
                if (load_done)
                    state_next = SERVE;
                else if (load_valid)
                    state_next = LOADING;
            end
            LOADING:  if (load_done) state_next = SERVE;
            SERVE:    if (finish) state_next = COMPLETE;
            COMPLETE: state_next = COMPLETE;
            default:  state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            RGB_ready <= 1'b0;
            done      <= 1'b0;
            gray_cnt  <= '0;
            lbp_cnt   <= '0;
            rd_data   <= '0;
        end else begin
            state     <= state_next;
            RGB_ready <= (state_next == SERVE);
            if (state == SERVE && finish)
                done <= 1'b1;
            if (gray_en && gray_cnt != CNT_MAX)
                gray_cnt <= gray_cnt + 1'b1;
            if (lbp_en && lbp_cnt != CNT_MAX)
                lbp_cnt <= lbp_cnt + 1'b1;
            rd_data <= rd_sel ? lbp_mem[rd_addr] : gray_mem[rd_addr];
        end
    end

    // Memories are deliberately not reset so an image survives a reset
    always_ff @(posedge clk) begin
        if (load_en)
            image_mem[load_addr] <= load_data;
        if (gray_en)
            gray_mem[gray_addr] <= gray_data;
        if (lbp_en)
            lbp_mem[lbp_addr] <= lbp_data;
    end

    assign RGB_data = RGB_req ? image_mem[RGB_addr] : '0;

`ifdef LBP_HOST_PROTOCOL_CHECK_EN
    logic proto_err;

    always_comb begin
        proto_err = 1'b0;
        if (RGB_req && !RGB_ready)
            proto_err = 1'b1;
        if ((gray_valid || lbp_valid) && (state == EMPTY || state == LOADING))
            proto_err = 1'b1;
        if (gray_valid && ({1'b0, gray_addr} != gray_cnt))
            proto_err = 1'b1;
        if (lbp_valid && lbp_cnt == CNT_MAX)
            proto_err = 1'b1;
        if (finish && gray_cnt < CNT_MAX)
            proto_err = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else if (proto_err)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lbp_host_mem.sv
// tb/tb_lbp_host_mem.sv - directed self-checking bench for lbp_host_mem
module tb_lbp_host_mem;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 16384;
    localparam int PIX_W  = 24;

`ifdef LBP_HOST_PROTOCOL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [PIX_W-1:0]  load_data;
    logic              load_done;
    logic              RGB_ready;
    logic              RGB_req;
    logic [ADDR_W-1:0] RGB_addr;
    logic [PIX_W-1:0]  RGB_data;
    logic              gray_valid;
    logic [ADDR_W-1:0] gray_addr;
    logic [7:0]        gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              finish;
    logic              rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [ADDR_W:0]   gray_cnt;
    logic [ADDR_W:0]   lbp_cnt;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    lbp_host_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PIX_W(PIX_W)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_done(load_done), .RGB_ready(RGB_ready), .RGB_req(RGB_req),
        .RGB_addr(RGB_addr), .RGB_data(RGB_data),
        .gray_valid(gray_valid), .gray_addr(gray_addr), .gray_data(gray_data),
        .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
        .finish(finish), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
        .gray_cnt(gray_cnt), .lbp_cnt(lbp_cnt), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        load_valid = 0; load_addr = '0; load_data = '0; load_done = 0;
        RGB_req = 0; RGB_addr = '0;
        gray_valid = 0; gray_addr = '0; gray_data = '0;
        lbp_valid = 0; lbp_addr = '0; lbp_data = '0;
        finish = 0; rd_sel = 0; rd_addr = '0;
        repeat (2) tick();

        check("rst_ready", RGB_ready, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_gray_cnt", gray_cnt, 0);
        check("rst_lbp_cnt", lbp_cnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        reset = 1'b1;
        tick();
        RGB_req = 1; RGB_addr = '0;
        tick();
        RGB_req = 0;
        check("err_req_early", err, EXP_ERR);
        reset = 1'b0;
        #1;
        check("err_cleared", err, 0);
        tick();
        reset = 1'b1;

        for (int i = 0; i < DEPTH - 1; i++) begin
            load_valid = 1; load_addr = 14'(i); load_data = 24'(i * 3);
            tick();
            if (i == 0) check("ready_loading", RGB_ready, 0);
        end
        load_addr = 14'(DEPTH - 1); load_data = 24'((DEPTH - 1) * 3); load_done = 1;
        tick();
        load_valid = 0; load_done = 0;
        check("ready_after_done", RGB_ready, 1);

        RGB_req = 1; RGB_addr = 14'd100;
        #1 check("rgb_100", RGB_data, 300);
        RGB_addr = 14'(DEPTH - 1);
        #1 check("rgb_last_same_cycle_load", RGB_data, 49149);
        RGB_req = 0;
        #1 check("rgb_idle_zero", RGB_data, 0);

        for (int i = 0; i < 5; i++) begin
            gray_valid = 1; gray_addr = 14'(i); gray_data = 8'(i);
            tick();
        end
        gray_addr = 14'd5; gray_data = 8'hAA;
        lbp_valid = 1; lbp_addr = 14'd5; lbp_data = 8'h55;
        tick();
        gray_valid = 0; lbp_valid = 0;
        check("gray_cnt_6", gray_cnt, 6);
        check("lbp_cnt_1", lbp_cnt, 1);
        check("err_in_order", err, 0);

        gray_valid = 1; gray_addr = 14'd7; gray_data = 8'd7;
        tick();
        gray_valid = 0;
        check("err_out_of_order", err, EXP_ERR);
        check("gray_cnt_7", gray_cnt, 7);

        rd_sel = 0; rd_addr = 14'd5;
        tick();
        check("rd_gray_5", rd_data, 8'hAA);
        rd_sel = 1;
        tick();
        check("rd_lbp_5", rd_data, 8'h55);

        for (int i = 6; i < DEPTH; i++) begin
            gray_valid = 1; gray_addr = 14'(i); gray_data = 8'(i);
            tick();
        end
        gray_valid = 0;
        check("gray_cnt_sat", gray_cnt, DEPTH);

        rd_sel = 0; rd_addr = 14'd258;
        gray_valid = 1; gray_addr = 14'd258; gray_data = 8'h77;
        tick();
        gray_valid = 0;
        check("rd_collision_old", rd_data, 2);
        tick();
        check("rd_after_write", rd_data, 8'h77);
        check("gray_cnt_no_wrap", gray_cnt, DEPTH);

        finish = 1;
        tick();
        finish = 0;
        check("done_set", done, 1);
        check("ready_fall", RGB_ready, 0);

        load_valid = 1; load_addr = 14'd100; load_data = 24'hABCDEF;
        tick();
        load_valid = 0;
        lbp_valid = 1; lbp_addr = 14'd9; lbp_data = 8'h3C;
        tick();
        lbp_valid = 0;
        check("lbp_cnt_complete", lbp_cnt, 2);
        rd_sel = 1; rd_addr = 14'd9;
        tick();
        check("rd_lbp_9", rd_data, 8'h3C);
        RGB_req = 1; RGB_addr = 14'd100;
        #1 check("load_ignored", RGB_data, 300);
        RGB_req = 0;

        reset = 0;
        tick();
        reset = 1;
        load_done = 1;
        tick();
        load_done = 0;
        check("ready_reuse", RGB_ready, 1);
        for (int i = 0; i < 500; i++) begin
            gray_valid = 1; gray_addr = 14'(i); gray_data = 8'(i);
            tick();
        end
        gray_valid = 0;
        check("gray_cnt_500", gray_cnt, 500);

        #2 reset = 0;
        #1;
        check("async_gray_cnt", gray_cnt, 0);
        check("async_lbp_cnt", lbp_cnt, 0);
        check("async_ready", RGB_ready, 0);
        check("async_done", done, 0);
        check("async_err", err, 0);
        check("async_rd_data", rd_data, 0);
        tick();
        reset = 1;
        tick();
        check("ready_empty", RGB_ready, 0);
        load_done = 1;
        tick();
        load_done = 0;
        check("ready_reload", RGB_ready, 1);
        RGB_req = 1; RGB_addr = 14'd100;
        #1 check("image_intact_100", RGB_data, 300);
        RGB_addr = 14'd4000;
        #1 check("image_intact_4000", RGB_data, 12000);
        RGB_req = 0;
        check("done_after_reset", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
